// File: rtl/program_loader.sv
// program_loader
//   Instruction-side partner of the 8-bit core. Accepts a program as a byte
//   stream over a valid/ready handshake, stores it in an internal instruction
//   memory, holds the core stopped while loading, then serves instruction
//   bytes combinationally from the core's pc. Reports fetches beyond the
//   loaded program (sticky) and supports reloading via restart.
//
// Parameters
//   DEPTH        instruction memory depth in bytes (must be 256 to cover pc)
//   FILL         byte driven on instruction while loading or pc out of range
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-low reset
//   load_valid   producer has a program byte on load_data
//   load_data    program byte
//   load_last    marks the final program byte (sampled on accept only)
//   load_ready   loader can accept a byte this cycle (LOAD state)
//   restart      pulse in RUN returns to LOAD for a new program
//   pc           fetch address from the core
//   instruction  instruction byte to the core
//   cpu_run      1 = core may execute (core reset is !cpu_run)
//   prog_len     number of bytes loaded, 0..256
//   oob          sticky: core fetched pc >= prog_len during RUN
module program_loader #(
  parameter int unsigned DEPTH = 256,
  parameter logic [7:0]  FILL  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       restart,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_run,
  output logic [8:0] prog_len,
  output logic       oob
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_wr_ptr;
  logic [8:0] r_prog_len;
  logic       r_oob;
  logic       w_accept;
  logic       w_restart;
  logic       w_pc_oob;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    cpu_run     = 1'b0;
    w_accept    = 1'b0;
    w_restart   = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        load_ready = 1'b1;
        w_accept   = load_valid;
        // The 256th byte ends loading regardless of load_last.
        if (w_accept && (load_last || (r_prog_len == 9'd255))) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cpu_run   = 1'b1;
        w_restart = restart;
        if (w_restart) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Write pointer, program length and sticky out-of-bounds flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_oob      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + 8'd1;
        r_prog_len <= r_prog_len + 9'd1;
      end
      if (w_restart) begin
        r_wr_ptr   <= '0;
        r_prog_len <= '0;
        r_oob      <= 1'b0;
      end else if (cpu_run && w_pc_oob) begin
        r_oob <= 1'b1;
      end
    end
  end

  // Memory has no reset; the write is gated by reset so that load_ready
  // being high during reset cannot let a byte slip in.
  always_ff @(posedge clk) begin
    if (w_accept && reset) begin
      r_mem[r_wr_ptr] <= load_data;
    end
  end

  assign w_pc_oob = ({1'b0, pc} >= r_prog_len);

  always_comb begin
    instruction = FILL;
    if (cpu_run && !w_pc_oob) begin
      instruction = r_mem[pc];
    end
  end

  assign prog_len = r_prog_len;
  assign oob      = r_oob;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       restart;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       cpu_run;
  logic [8:0] prog_len;
  logic       oob;

  int unsigned checks;
  int unsigned failures;

  program_loader #(
    .DEPTH (256),
    .FILL  (8'h00)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .restart     (restart),
    .pc          (pc),
    .instruction (instruction),
    .cpu_run     (cpu_run),
    .prog_len    (prog_len),
    .oob         (oob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    pc = addr;
    #1;
    check(tag, instruction, exp);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  logic [7:0] gap_exp;

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    load_last  = 1'b1;
    restart    = 1'b0;
    pc         = 8'h00;

    // Reset state, with a transfer offered during reset (must be ignored)
    #2;
    check("rst_ready", load_ready, 1);
    check("rst_run", cpu_run, 0);
    check("rst_instr", instruction, 8'h00);
    check("rst_len", prog_len, 0);
    check("rst_oob", oob, 0);
    tick();
    tick();
    check("rst_noaccept_len", prog_len, 0);
    check("rst_noaccept_run", cpu_run, 0);
    load_valid = 1'b0;
    load_last  = 1'b0;
    reset      = 1'b1;

    // Basic load and fetch, back-to-back
    load_valid = 1'b1;
    load_data = 8'h41; load_last = 1'b0; tick();
    check("basic_run_mid", cpu_run, 0);
    load_data = 8'h82; tick();
    load_data = 8'hC3; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("basic_len", prog_len, 3);
    check("basic_run", cpu_run, 1);
    check("basic_ready", load_ready, 0);
    fetch("basic_pc0", 8'd0, 8'h41);
    fetch("basic_pc1", 8'd1, 8'h82);
    fetch("basic_pc2", 8'd2, 8'hC3);
    check("basic_oob_pre", oob, 0);
    fetch("basic_pc3", 8'd3, 8'h00);
    check("basic_oob_same_cycle", oob, 0);
    tick();
    check("basic_oob_set", oob, 1);
    pc = 8'd0;
    tick();
    check("basic_oob_sticky", oob, 1);
    // load_valid in RUN is ignored
    send(8'h55, 1'b1);
    check("run_ignore_len", prog_len, 3);
    fetch("run_ignore_pc0", 8'd0, 8'h41);

    // Restart, then single-byte program
    do_restart();
    check("rs_run", cpu_run, 0);
    check("rs_ready", load_ready, 1);
    check("rs_len", prog_len, 0);
    check("rs_oob", oob, 0);
    check("rs_instr", instruction, 8'h00);
    // restart in LOAD is ignored
    do_restart();
    check("rs_load_ignored", cpu_run, 0);
    send(8'h15, 1'b1);
    check("rs_len1", prog_len, 1);
    check("rs_run1", cpu_run, 1);
    fetch("rs_pc0", 8'd0, 8'h15);
    fetch("rs_pc1", 8'd1, 8'h00);
    tick();
    check("rs_oob_pc1", oob, 1);

    // Handshake gaps: only valid cycles write
    do_restart();
    load_valid = 1'b1; load_data = 8'h11; tick();
    load_valid = 1'b0; load_data = 8'hFF; tick();
    load_valid = 1'b1; load_data = 8'h22; tick();
    load_valid = 1'b0; load_data = 8'hFF; tick();
    check("gap_len2", prog_len, 2);
    check("gap_still_load", cpu_run, 0);
    send(8'h33, 1'b1);
    check("gap_len3", prog_len, 3);
    for (int unsigned a = 0; a < 256; a++) begin
      case (a)
        0: gap_exp = 8'h11;
        1: gap_exp = 8'h22;
        2: gap_exp = 8'h33;
        default: gap_exp = 8'h00;
      endcase
      fetch("gap_scan", 8'(a), gap_exp);
    end

    // Full memory: 256 bytes, load_last never asserted
    do_restart();
    check("full_oob_clr", oob, 0);
    for (int unsigned i = 0; i < 256; i++) begin
      check("full_ready", load_ready, 1);
      send(8'(i), 1'b0);
    end
    check("full_len", prog_len, 256);
    check("full_run", cpu_run, 1);
    check("full_ready_off", load_ready, 0);
    for (int unsigned a = 0; a < 256; a++) begin
      fetch("full_fetch", 8'(a), 8'(a));
      tick();
    end
    check("full_oob_never", oob, 0);
    fetch("full_pcFF", 8'hFF, 8'hFF);
    send(8'h77, 1'b1);
    check("full_no_more_len", prog_len, 256);
    fetch("full_pc0_kept", 8'h00, 8'h00);

    // Reset mid-load after 2 of 5 bytes
    do_restart();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    check("mid_len2", prog_len, 2);
    load_valid = 1'b1; load_data = 8'hA3;
    #2;
    reset = 1'b0;
    #1;
    check("mid_ready", load_ready, 1);
    check("mid_run", cpu_run, 0);
    check("mid_len0", prog_len, 0);
    check("mid_oob", oob, 0);
    check("mid_instr", instruction, 8'h00);
    tick();
    check("mid_noaccept", prog_len, 0);
    load_valid = 1'b0;
    reset = 1'b1;
    send(8'h99, 1'b1);
    check("mid_reload_len", prog_len, 1);
    check("mid_reload_run", cpu_run, 1);
    fetch("mid_pc0", 8'd0, 8'h99);
    fetch("mid_pc1", 8'd1, 8'h00);

    // Reset mid-run clears oob and stops the core immediately
    tick();
    check("midrun_oob_set", oob, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrun_run", cpu_run, 0);
    check("midrun_oob", oob, 0);
    check("midrun_len", prog_len, 0);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against an unexpected hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
